// File: rtl/stream_window_sum.sv
// Sliding-window sum over the last LENGTH accepted samples, using an external delay chain for history.
// Latency: one clock from an accepted sample to o_val with the updated sum.
// Backpressure: single output register; i_rdy = !o_val | o_rdy, so a stalled output stalls input and the chain.
module stream_window_sum #(
    parameter int WIDTH  = 16,
    parameter int LENGTH = 64
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                clear,
    input  logic [WIDTH-1:0]                    i_dat,
    input  logic                                i_val,
    output logic                                i_rdy,
    output logic [WIDTH+$clog2(LENGTH)-1:0]     o_dat,
    output logic                                o_val,
    input  logic                                o_rdy,
    output logic                                o_full,
    output logic                                chain_ena,
    output logic [WIDTH-1:0]                    chain_idat,
    input  logic [WIDTH-1:0]                    chain_odat
);

    localparam int SWIDTH = WIDTH + $clog2(LENGTH);
    localparam int CW     = $clog2(LENGTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LENGTH);

    logic [SWIDTH-1:0] sum;
    logic [SWIDTH-1:0] sum_next;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;
    logic [WIDTH-1:0]  leaving;
    logic              accept;

    assign i_rdy      = !o_val || o_rdy;
    assign accept     = i_val && i_rdy && !clear;
    assign chain_ena  = accept;
    assign chain_idat = i_dat;
    assign o_dat      = sum;

    // Next window state: the tail sample only leaves once the window is fully populated,
    // so chain contents left over from before reset/clear never reach the sum.
    always_comb begin
        leaving  = '0;
        cnt_next = cnt;
        if (cnt == CNT_MAX) begin
            leaving = chain_odat;
        end
        if (cnt != CNT_MAX) begin
            cnt_next = cnt + 1'b1;
        end
        // Modular arithmetic at SWIDTH bits: the true result always fits, so any
        // intermediate wrap of sum + i_dat cancels out in the subtraction.
        sum_next = sum + SWIDTH'(i_dat) - SWIDTH'(leaving);
    end

    // Window sum, fill count and full flag; clear has priority over a concurrent accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum    <= '0;
            cnt    <= '0;
            o_full <= 1'b0;
        end else if (clear) begin
            sum    <= '0;
            cnt    <= '0;
            o_full <= 1'b0;
        end else if (accept) begin
            sum    <= sum_next;
            cnt    <= cnt_next;
            o_full <= (cnt_next == CNT_MAX);
        end
    end

    // Output valid: set by an accept, dropped when consumed without a replacement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_val <= 1'b0;
        end else if (clear) begin
            o_val <= 1'b0;
        end else if (accept) begin
            o_val <= 1'b1;
        end else if (o_rdy) begin
            o_val <= 1'b0;
        end
    end

endmodule

// File: doc/stream_window_sum.md
STREAM_WINDOW_SUM -- requirements
Module: stream_window_sum

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample width in bits.
REQ-002 SHALL have parameter LENGTH, default 64, window length in samples; must match the external delay chain length; LENGTH >= 1.
REQ-003 SHALL have derived localparam SWIDTH = WIDTH + $clog2(LENGTH), sum width.
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 clear  input  1  synchronous window flush.
REQ-008 i_dat  input  WIDTH  input sample, unsigned.
REQ-009 i_val  input  1  input sample valid.
REQ-010 i_rdy  output  1  block can accept a sample.
REQ-011 o_dat  output  SWIDTH  current window sum, unsigned.
REQ-012 o_val  output  1  o_dat valid.
REQ-013 o_rdy  input  1  downstream accepts o_dat.
REQ-014 o_full  output  1  window fully populated (LENGTH samples since last reset/clear).
REQ-015 chain_ena  output  1  clock enable to external delay chain.
REQ-016 chain_idat  output  WIDTH  sample written into chain head.
REQ-017 chain_odat  input  WIDTH  sample at chain tail (oldest entry).

Function
REQ-018 SHALL define accept = i_val & i_rdy & !clear.
REQ-019 SHALL drive i_rdy = !o_val | o_rdy (combinational; single output register).
REQ-020 SHALL drive chain_ena = accept and chain_idat = i_dat combinationally; chain shifts exactly once per accepted sample, never otherwise.
REQ-021 SHALL keep fill counter cnt in range 0..LENGTH; increment on accept while cnt < LENGTH, saturate at LENGTH.
REQ-022 SHALL define leaving = chain_odat when cnt == LENGTH, else 0 (masks unreset/stale chain contents).
REQ-023 SHALL on accept update sum <= sum + i_dat - leaving, computed at SWIDTH bits; result never wraps because sum <= LENGTH*(2^WIDTH-1).
REQ-024 SHALL drive o_dat from the registered sum; latency from accept to o_val = 1 clock.
REQ-025 SHALL set o_val on the edge after accept; clear o_val on o_val & o_rdy without a simultaneous accept; hold o_dat/o_val stable while o_val & !o_rdy.
REQ-026 SHALL, on o_val & o_rdy with simultaneous accept, keep o_val = 1 and present the new sum next cycle (full throughput, one sample per clock).
REQ-027 SHALL drive o_full = (cnt == LENGTH) registered; o_full asserts on the edge of the LENGTH-th accept.
REQ-028 SHALL on clear (priority over accept): sum <= 0, cnt <= 0, o_val <= 0, o_full <= 0; chain_ena = 0 that cycle; i_rdy still per REQ-019 but no sample is taken.
REQ-029 SHALL not depend on chain contents after reset/clear; stale chain data is masked by REQ-022 until LENGTH new samples are shifted.

Reset
REQ-030 SHALL on reset asynchronously force sum = 0, cnt = 0, o_val = 0, o_full = 0; hence o_dat = 0, i_rdy = 1, chain_ena = 0 while i_val = 0.
REQ-031 SHALL, on reset asserted mid-stream, discard all in-flight and window state; the first sample after reset yields o_dat = that sample.

Verification (WIDTH=8, LENGTH=4, ramchain model attached, o_rdy=1 unless stated)
REQ-032 Fill/slide: accept 1,2,3,4,5,6 back-to-back -> o_dat 1,3,6,10,14,18 on consecutive cycles; o_full rises with sum 10.
REQ-033 Backpressure: after sum 3, hold o_rdy=0 for 3 cycles with i_val=1 -> i_rdy=0, o_dat stays 3, chain_ena=0; release -> 6 next cycle, no sample lost or duplicated.
REQ-034 Max value: accept 255 six times -> sums 255,510,765,1020,1020,1020; no overflow in 10-bit o_dat.
REQ-035 Clear vs accept: window full (sum 18), assert clear with i_val=1 and i_dat=9 -> next cycle o_val=0, o_full=0, sum 0, chain not shifted; then accept 7 -> o_dat 7.
REQ-036 Async reset mid-stream: after 5 samples, pulse reset between edges -> outputs zero immediately; accept 2,2,2,2,2 -> 2,4,6,8,8 (stale chain contents masked).
